pool_window_2x2: RTL and testbench

//  Upstream stage of the 2x2 max-pool comparator tree. Takes a raster-order pixel stream of one

---
 rtl/pool_window_2x2.sv | 131 +++++++++++++
 tb/tb_pool_window_2x2.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_2x2.sv
// Stride-2 2x2 window former: one row held in a line buffer, windows completed by the odd row.
// Optional POOL_VALID_ALIGN_EN adds pool_valid, a 2-cycle delayed copy of win_valid.
module pool_window_2x2 #(
    parameter int WIDTH    = 8,
    parameter int MAX_COLS = 416,
    parameter int COL_W    = 9,
    parameter int ROW_W    = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [COL_W-1:0]        cfg_cols,
    input  logic [ROW_W-1:0]        cfg_rows,
    input  logic                    din_valid,
    input  logic signed [WIDTH-1:0] din,
    output logic                    busy,
    output logic                    win_valid,
    output logic signed [WIDTH-1:0] val1_1,
    output logic signed [WIDTH-1:0] val1_2,
    output logic signed [WIDTH-1:0] val2_1,
    output logic signed [WIDTH-1:0] val2_2,
    output logic                    frame_done,
    output logic                    cfg_err
`ifdef POOL_VALID_ALIGN_EN
    ,
    output logic                    pool_valid
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_next;
    logic [COL_W-1:0]        cols_q, col;
    logic [ROW_W-1:0]        rows_q, row;
    logic signed [WIDTH-1:0] left_pix;
    logic signed [WIDTH-1:0] linebuf [MAX_COLS];

    logic cfg_ok, launch, accept, last_col, last_row, last_pix, odd_row, odd_col;

    assign cfg_ok   = (cfg_cols >= COL_W'(2)) && (int'(cfg_cols) <= MAX_COLS)
                      && (cfg_rows >= ROW_W'(2));
    assign launch   = (state == IDLE) && start && cfg_ok;
    assign accept   = din_valid && (state == RUN);
    assign last_col = (col == cols_q - COL_W'(1));
    assign last_row = (row == rows_q - ROW_W'(1));
    assign last_pix = accept && last_col && last_row;
    assign odd_row  = row[0];
    assign odd_col  = col[0];

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (launch)   state_next = RUN;
            RUN:     if (last_pix) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == RUN);
        frame_done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cols_q    <= '0;
            rows_q    <= '0;
            col       <= '0;
            row       <= '0;
            left_pix  <= '0;
            cfg_err   <= 1'b0;
            win_valid <= 1'b0;
            val1_1    <= '0;
            val1_2    <= '0;
            val2_1    <= '0;
            val2_2    <= '0;
        end else begin
            cfg_err   <= (state == IDLE) && start && !cfg_ok;
            win_valid <= accept && odd_row && odd_col;

            if (launch) begin
                cols_q <= cfg_cols;
                rows_q <= cfg_rows;
                col    <= '0;
                row    <= '0;
            end else if (accept) begin
                if (last_col) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            if (accept && odd_row && !odd_col) left_pix <= din;

            // An odd column always has its even partner, so a trailing odd column never lands here.
            if (accept && odd_row && odd_col) begin
                val1_1 <= linebuf[col - COL_W'(1)];
                val1_2 <= linebuf[col];
                val2_1 <= left_pix;
                val2_2 <= din;
            end
        end
    end

    // NOTE: line buffer is plain storage without reset; every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (accept && !odd_row) linebuf[col] <= din;
    end

`ifdef POOL_VALID_ALIGN_EN
    logic [1:0] pool_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pool_pipe <= '0;
        else        pool_pipe <= {pool_pipe[0], win_valid};
    end

    assign pool_valid = pool_pipe[1];
`endif

endmodule

// File: tb/tb_pool_window_2x2.sv
// Randomized bench for pool_window_2x2; windows are predicted from the stored image by arithmetic.
// Build with POOL_VALID_ALIGN_EN to also check pool_valid alignment.
module tb_pool_window_2x2;

    localparam int WIDTH    = 8;
    localparam int MAX_COLS = 416;
    localparam int COL_W    = 9;
    localparam int ROW_W    = 9;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic [COL_W-1:0]        cfg_cols;
    logic [ROW_W-1:0]        cfg_rows;
    logic                    din_valid;
    logic signed [WIDTH-1:0] din;
    logic                    busy, win_valid, frame_done, cfg_err;
    logic signed [WIDTH-1:0] val1_1, val1_2, val2_1, val2_2;
`ifdef POOL_VALID_ALIGN_EN
    logic                    pool_valid;
`endif

    pool_window_2x2 #(.WIDTH(WIDTH), .MAX_COLS(MAX_COLS), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
        .din_valid(din_valid), .din(din), .busy(busy), .win_valid(win_valid),
        .val1_1(val1_1), .val1_2(val1_2), .val2_1(val2_1), .val2_2(val2_2),
        .frame_done(frame_done), .cfg_err(cfg_err)
`ifdef POOL_VALID_ALIGN_EN
        , .pool_valid(pool_valid)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edges = 0;

    always @(posedge clk) edges <= edges + 1;

    // Observed events, tagged with the number of rising edges seen so far
    logic [31:0] win_q [$];
    int          win_e [$];
    int          fd_e  [$];
    int          pv_e  [$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (win_valid) begin
                win_q.push_back({val1_1, val1_2, val2_1, val2_2});
                win_e.push_back(edges);
            end
            if (frame_done) fd_e.push_back(edges);
`ifdef POOL_VALID_ALIGN_EN
            if (pool_valid) pv_e.push_back(edges);
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        win_q.delete();
        win_e.delete();
        fd_e.delete();
        pv_e.delete();
    endtask

    // Reference image and the edge at which each pixel was accepted
    logic signed [WIDTH-1:0] img [$];
    int                      acc [$];

    // vmode 0: din = pixel index; 1: random (first two forced to -128, -1)
    // gmode 0: continuous; 1: one gap between pixels; 2: random gaps with stray starts
    task automatic run_frame(input string name, input int cols, input int rows,
                             input int vmode, input int gmode);
        logic signed [WIDTH-1:0] pix;
        int n_win, p11, p12, p21, p22, w;
        clear_obs();
        img.delete();
        acc.delete();
        cfg_cols = COL_W'(cols);
        cfg_rows = ROW_W'(rows);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check({name, "/busy_run"}, 32'(busy), 1);
        for (int p = 0; p < cols * rows; p++) begin
            int gaps;
            gaps = (gmode == 1 && p > 0) ? 1 : (gmode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                din_valid = 1'b0;
                din       = WIDTH'($urandom);
                if (gmode == 2 && $urandom_range(0, 3) == 0) begin
                    cfg_cols = COL_W'(2);
                    cfg_rows = ROW_W'(2);
                    start    = 1'b1;
                end
                tick();
                start    = 1'b0;
                cfg_cols = COL_W'(cols);
                cfg_rows = ROW_W'(rows);
            end
            if (vmode == 0)  pix = WIDTH'(p);
            else if (p == 0) pix = -8'sd128;
            else if (p == 1) pix = -8'sd1;
            else             pix = WIDTH'($urandom);
            din       = pix;
            din_valid = 1'b1;
            img.push_back(pix);
            acc.push_back(edges + 1);
            tick();
            din_valid = 1'b0;
        end
        repeat (3) tick();

        n_win = (cols / 2) * (rows / 2);
        check({name, "/win_count"}, win_q.size(), n_win);
        for (int r = 0; r < rows / 2; r++) begin
            for (int c = 0; c < cols / 2; c++) begin
                w   = r * (cols / 2) + c;
                p11 = (2 * r) * cols + 2 * c;
                p12 = p11 + 1;
                p21 = p11 + cols;
                p22 = p21 + 1;
                if (w < win_q.size()) begin
                    check({name, "/win_val"}, win_q[w], {img[p11], img[p12], img[p21], img[p22]});
                    check({name, "/win_lat"}, win_e[w], acc[p22]);
                end
            end
        end
        check({name, "/done_count"}, fd_e.size(), 1);
        if (fd_e.size() > 0) check({name, "/done_edge"}, fd_e[0], acc[cols * rows - 1]);
        check({name, "/busy_idle"}, 32'(busy), 0);
`ifdef POOL_VALID_ALIGN_EN
        check({name, "/pool_count"}, pv_e.size(), win_e.size());
        for (int i = 0; i < pv_e.size() && i < win_e.size(); i++)
            check({name, "/pool_edge"}, pv_e[i], win_e[i] + 2);
`endif
    endtask

    task automatic bad_cfg(input string name, input int cols, input int rows);
        clear_obs();
        cfg_cols = COL_W'(cols);
        cfg_rows = ROW_W'(rows);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check({name, "/cfg_err_hi"}, 32'(cfg_err), 1);
        check({name, "/busy"}, 32'(busy), 0);
        din_valid = 1'b1;
        din       = 8'sd55;
        tick();
        din_valid = 1'b0;
        check({name, "/cfg_err_lo"}, 32'(cfg_err), 0);
        repeat (2) tick();
        check({name, "/no_win"}, win_q.size(), 0);
        check({name, "/busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_cols  = '0;
        cfg_rows  = '0;
        din_valid = 1'b0;
        din       = '0;
        #12;
        check("reset/busy", 32'(busy), 0);
        check("reset/win_valid", 32'(win_valid), 0);
        check("reset/vals", {val1_1, val1_2, val2_1, val2_2}, 0);
        check("reset/frame_done", 32'(frame_done), 0);
        check("reset/cfg_err", 32'(cfg_err), 0);
        rst_n = 1'b1;
        tick();

        // Pixels offered while idle must be dropped
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = WIDTH'(100 + i);
            tick();
        end
        din_valid = 1'b0;
        check("idle/busy", 32'(busy), 0);

        run_frame("c1_4x4", 4, 4, 0, 0);
        run_frame("c2_4x4_gap", 4, 4, 0, 1);
        run_frame("c3_5x3", 5, 3, 0, 0);

        bad_cfg("c4_cols1", 1, 4);
        bad_cfg("c4_colsmax1", MAX_COLS + 1, 4);
        bad_cfg("c4_rows1", 4, 1);

        // Abort a frame right after its first window has been produced
        clear_obs();
        cfg_cols = COL_W'(4);
        cfg_rows = ROW_W'(4);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int p = 0; p < 6; p++) begin
            din       = WIDTH'(p);
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        check("c5/win_before_rst", 32'(win_valid), 1);
        rst_n = 1'b0;
        #1;
        check("c5/rst_busy", 32'(busy), 0);
        check("c5/rst_win_valid", 32'(win_valid), 0);
        check("c5/rst_vals", {val1_1, val1_2, val2_1, val2_2}, 0);
        check("c5/rst_frame_done", 32'(frame_done), 0);
        #5;
        rst_n = 1'b1;
        tick();
        run_frame("c5_4x4_after", 4, 4, 0, 0);
        run_frame("c5_neg", 4, 4, 1, 0);

        run_frame("maxcols", MAX_COLS, 2, 1, 0);
        for (int k = 0; k < 5; k++)
            run_frame("rand", int'($urandom_range(2, 9)), int'($urandom_range(2, 7)), 1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
